// File: rtl/sqr_rebuild.sv
// Rebuilds a radical from a square root and its remainder: radical = q*q + rem,
// computed by a serial shift-add multiplier. Optional macro SQR_REBUILD_REM_CHECK_EN adds rem_err.
module sqr_rebuild #(
    parameter int unsigned Q_WIDTH   = 8,
    parameter int unsigned R_WIDTH   = 9,
    parameter int unsigned RAD_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 aclr,
    input  logic                 ena,
    input  logic                 start,
    input  logic [Q_WIDTH-1:0]   q_in,
    input  logic [R_WIDTH-1:0]   rem_in,
    output logic                 busy,
    output logic                 done,
    output logic [RAD_WIDTH-1:0] radical,
    output logic                 ovf
`ifdef SQR_REBUILD_REM_CHECK_EN
    ,
    output logic                 rem_err
`endif
);

    localparam int unsigned ACC_W = 2 * Q_WIDTH + 1;
    localparam int unsigned CNT_W = (Q_WIDTH > 1) ? $clog2(Q_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(Q_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state, state_next;
    logic [Q_WIDTH-1:0]   mcand, mcand_next;
    logic [Q_WIDTH-1:0]   mplier, mplier_next;
    logic [ACC_W-1:0]     acc, acc_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic                 busy_next, done_next, ovf_next;
    logic [RAD_WIDTH-1:0] radical_next;
    logic [ACC_W-1:0]     addend_c, acc_sum_c;
    logic                 hi_bits_c;

    // One partial product per step; multiplicand shifted by the step index.
    assign addend_c  = mplier[cnt] ? (ACC_W'(mcand) << cnt) : '0;
    assign acc_sum_c = acc + addend_c;

    generate
        if (RAD_WIDTH < ACC_W) begin : g_ovf
            assign hi_bits_c = |acc_sum_c[ACC_W-1:RAD_WIDTH];
        end else begin : g_no_ovf
            assign hi_bits_c = 1'b0;
        end
    endgenerate

`ifdef SQR_REBUILD_REM_CHECK_EN
    localparam int unsigned CMP_W = (R_WIDTH > Q_WIDTH + 1) ? R_WIDTH : Q_WIDTH + 1;

    logic [R_WIDTH-1:0] rem_q, rem_q_next;
    logic               rem_err_next;
    logic               rem_bad_c;

    // A legal square-root remainder never exceeds 2*q.
    assign rem_bad_c = CMP_W'(rem_q) > CMP_W'({mcand, 1'b0});
`endif

    // Next-state and datapath update.
    always_comb begin
        state_next   = state;
        mcand_next   = mcand;
        mplier_next  = mplier;
        acc_next     = acc;
        cnt_next     = cnt;
        radical_next = radical;
        ovf_next     = ovf;
`ifdef SQR_REBUILD_REM_CHECK_EN
        rem_q_next   = rem_q;
        rem_err_next = rem_err;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    mcand_next  = q_in;
                    mplier_next = q_in;
                    acc_next    = ACC_W'(rem_in);
                    cnt_next    = '0;
                    state_next  = MUL;
`ifdef SQR_REBUILD_REM_CHECK_EN
                    rem_q_next  = rem_in;
`endif
                end
            end
            MUL: begin
                acc_next = acc_sum_c;
                cnt_next = cnt + CNT_W'(1);
                if (cnt == LAST_STEP) begin
                    cnt_next     = '0;
                    state_next   = DONE;
                    radical_next = RAD_WIDTH'(acc_sum_c);
                    ovf_next     = hi_bits_c;
`ifdef SQR_REBUILD_REM_CHECK_EN
                    rem_err_next = rem_bad_c;
`endif
                end
            end
            DONE: begin
                // A start seen here is dropped; a new request must arrive in IDLE.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next != IDLE);
        done_next = (state_next == DONE);
    end

    // State, datapath and output registers; everything freezes while ena is low.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state   <= IDLE;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            radical <= '0;
            ovf     <= 1'b0;
`ifdef SQR_REBUILD_REM_CHECK_EN
            rem_q   <= '0;
            rem_err <= 1'b0;
`endif
        end else if (ena) begin
            state   <= state_next;
            mcand   <= mcand_next;
            mplier  <= mplier_next;
            acc     <= acc_next;
            cnt     <= cnt_next;
            busy    <= busy_next;
            done    <= done_next;
            radical <= radical_next;
            ovf     <= ovf_next;
`ifdef SQR_REBUILD_REM_CHECK_EN
            rem_q   <= rem_q_next;
            rem_err <= rem_err_next;
`endif
        end
    end

endmodule

// File: doc/sqr_rebuild.md
SQR_REBUILD -- requirements
Module: sqr_rebuild

Interface
REQ-001 The module SHALL have parameter Q_WIDTH, default 8, giving the width of the root operand.
REQ-002 The module SHALL have parameter R_WIDTH, default 9, giving the width of the remainder operand.
REQ-003 The module SHALL have parameter RAD_WIDTH, default 16, giving the width of the rebuilt radical.
REQ-004 The module SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 The module SHALL have port aclr, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The module SHALL have port ena, input, 1 bit: clock enable; when low, all state and outputs freeze.
REQ-007 The module SHALL have port start, input, 1 bit: request a new operation.
REQ-008 The module SHALL have port q_in, input, Q_WIDTH bits: the square-root operand.
REQ-009 The module SHALL have port rem_in, input, R_WIDTH bits: the remainder operand.
REQ-010 The module SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-011 The module SHALL have port done, output, 1 bit: high for the single completion cycle.
REQ-012 The module SHALL have port radical, output, RAD_WIDTH bits: q*q + rem, taken modulo 2^RAD_WIDTH.
REQ-013 The module SHALL have port ovf, output, 1 bit: the exact result did not fit in RAD_WIDTH bits.

Function
REQ-014 The state machine SHALL have three states: IDLE, MUL and DONE.
REQ-015 In IDLE, when start=1 and ena=1, the module SHALL:
- latch q_in as both multiplicand and multiplier;
- load the accumulator with rem_in, zero-extended to 2*Q_WIDTH+1 bits;
- clear the step counter and enter MUL.
REQ-016 In MUL, each enabled cycle SHALL perform one shift-add step:
- if multiplier bit k is 1, add (multiplicand << k) to the accumulator;
- k runs from 0 to Q_WIDTH-1.
REQ-017 The accumulator SHALL be 2*Q_WIDTH+1 bits wide so that no intermediate result overflows.
REQ-018 After step Q_WIDTH-1, the FSM SHALL enter DONE and on that same edge:
- register radical = acc[RAD_WIDTH-1:0];
- register ovf = OR of accumulator bits at or above RAD_WIDTH (0 if RAD_WIDTH >= 2*Q_WIDTH+1).
REQ-019 In DONE, done SHALL be 1 and the FSM SHALL return to IDLE on the next enabled edge.
REQ-020 With ena held high, latency SHALL be fixed: start sampled at edge N gives done high in the cycle after edge N+Q_WIDTH.
REQ-021 busy SHALL be 1 in the MUL and DONE states and 0 in IDLE.
REQ-022 start SHALL be ignored while busy=1; in-flight operands SHALL NOT change.
REQ-023 A start asserted in the same cycle that DONE returns to IDLE SHALL be ignored; a new request needs start high in IDLE.
REQ-024 radical and ovf SHALL hold their values until the next DONE entry.
REQ-025 With ena=0, the FSM, counter, accumulator and outputs SHALL hold. If frozen in DONE, done SHALL stay high until ena returns high.
REQ-026 When q_in=0, the result SHALL equal rem_in (truncated per REQ-018), with the same latency.

Reset
REQ-027 When aclr=1, the module SHALL immediately, regardless of clk and ena, force:
- state to IDLE;
- busy=0, done=0;
- radical=0, ovf=0;
- accumulator, counter and operand registers to 0.
REQ-028 An aclr asserted mid-operation SHALL abort that operation with no done pulse; the first start after aclr deasserts SHALL begin a fresh operation.

Configuration
REQ-029 When macro SQR_REBUILD_REM_CHECK_EN is defined, the module SHALL:
- add output port rem_err, 1 bit;
- register rem_err with radical on DONE entry, set to 1 when the latched remainder > 2*q (not a legal square-root remainder);
- reset rem_err to 0 and hold it under the same rules as ovf.
REQ-030 When SQR_REBUILD_REM_CHECK_EN is undefined, the port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (defaults Q_WIDTH=8, R_WIDTH=9, RAD_WIDTH=16, ena=1)
REQ-031 q_in=12, rem_in=5, start pulse -> done high exactly 9 cycles later, radical=149, ovf=0, busy low the cycle after done.
REQ-032 q_in=255, rem_in=510 -> radical=65535, ovf=0; with the macro defined, rem_err=0.
REQ-033 q_in=255, rem_in=511 -> radical=0, ovf=1; with the macro defined, rem_err=1.
REQ-034 Start q_in=3, rem_in=0; re-pulse start with q_in=100 at step 3 -> radical=9, and exactly one done pulse.
REQ-035 Drop ena low for 4 cycles mid-MUL -> done is delayed by 4 cycles, result is unchanged; holding ena low in DONE keeps done high.
REQ-036 Assert aclr at step 5 -> all outputs 0 at once, no done pulse; next start with q_in=7, rem_in=2 -> radical=51.
